// File: rtl/rx_stream_buffer_if.sv
// Purpose : AXI-Stream style beat bundle used on both sides of rx_stream_buffer.
// Latency : n/a (wires only).
// Backpressure: tready flows from the sink back to the source.
//
// Signals:
//   tdata  - beat data, DATA_WIDTH bits
//   tkeep  - byte enables, DATA_WIDTH/8 bits
//   tlast  - last beat of packet
//   tvalid - beat present
//   tready - sink can take the beat
interface rx_stream_buffer_if #(
  parameter int DATA_WIDTH = 64
) ();

  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic                    tvalid;
  logic                    tready;

  modport master (
    output tdata, tkeep, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tlast, tvalid,
    output tready
  );

endinterface

// File: rtl/rx_stream_buffer.sv
// Purpose : packet-mode ingress buffer; only complete packets reach m_axis, packets
//           that do not fit are dropped whole and flagged on a stretched overrun.
// Latency : m_axis.tvalid rises 2 cycles after the edge that writes a tlast beat.
// Backpressure: none on s_axis (beats are stored or dropped); m_axis honours tready.
//
// Ports:
//   rx_clk, rx_reset - clock and synchronous active-high reset
//   channel_up       - link status; while low, input is ignored and any partial packet is rewound
//   s_axis           - receive beats (slave side, tready tied high)
//   m_axis           - complete packets out (master side, first-word fall-through)
//   overrun          - high for OVERRUN_STRETCH cycles after the most recent drop
//   fill_level       - words held (committed + uncommitted), registered
//   drop_count       - dropped packets since reset, saturating
module rx_stream_buffer #(
  parameter int DATA_WIDTH      = 64,
  parameter int FIFO_DEPTH      = 512,
  parameter int OVERRUN_STRETCH = 16
) (
  input  logic                        rx_clk,
  input  logic                        rx_reset,
  input  logic                        channel_up,
  rx_stream_buffer_if.slave           s_axis,
  rx_stream_buffer_if.master          m_axis,
  output logic                        overrun,
  output logic [$clog2(FIFO_DEPTH):0] fill_level,
  output logic [15:0]                 drop_count
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int SW = $clog2(OVERRUN_STRETCH + 1);

  localparam logic [PW-1:0] DEPTH_P   = PW'(FIFO_DEPTH);
  localparam logic [SW-1:0] STRETCH_P = SW'(OVERRUN_STRETCH);

  typedef struct packed {
    logic          tlast;
    logic [KW-1:0] tkeep;
    logic [DATA_WIDTH-1:0] tdata;
  } beat_t;

  typedef enum logic {
    PASS    = 1'b0,
    DISCARD = 1'b1
  } state_t;

  // ---------------------------------------------------------------- storage
  beat_t mem [FIFO_DEPTH];

  // ---------------------------------------------------------------- state
  state_t        state_q, state_nxt;
  logic [PW-1:0] wr_ptr_q, wr_ptr_nxt;
  logic [PW-1:0] commit_ptr_q, commit_ptr_nxt;
  // rd_ptr frees space only when a beat leaves m_axis, so words sitting in the
  // read pipeline still count against capacity. fetch_ptr is the RAM read address.
  logic [PW-1:0] rd_ptr_q, rd_ptr_nxt;
  logic [PW-1:0] fetch_ptr_q;

  logic          ram_vld;
  beat_t         ram_dat;
  logic          out_vld;
  beat_t         out_dat;

  logic [SW-1:0] stretch_q;
  logic [PW-1:0] fill_q;
  logic [15:0]   drop_q;

  // ---------------------------------------------------------------- write side
  logic  full;
  logic  wr_en;
  logic  drop_evt;
  beat_t wr_beat;

  // The transceiver stream cannot be stalled; overflow is handled by dropping.
  assign s_axis.tready = 1'b1;

  assign full = (wr_ptr_q - rd_ptr_q) == DEPTH_P;

  always_comb begin
    wr_beat.tlast = s_axis.tlast;
    wr_beat.tkeep = s_axis.tkeep;
    wr_beat.tdata = s_axis.tdata;
  end

  always_comb begin
    state_nxt      = state_q;
    wr_ptr_nxt     = wr_ptr_q;
    commit_ptr_nxt = commit_ptr_q;
    wr_en          = 1'b0;
    drop_evt       = 1'b0;

    if (!channel_up) begin
      // Link loss: abandon the partial packet silently; committed data stays.
      wr_ptr_nxt = commit_ptr_q;
      state_nxt  = PASS;
    end else if (s_axis.tvalid) begin
      case (state_q)
        PASS: begin
          if (!full) begin
            wr_en      = 1'b1;
            wr_ptr_nxt = wr_ptr_q + PW'(1);
            if (s_axis.tlast) begin
              commit_ptr_nxt = wr_ptr_q + PW'(1);
            end
          end else begin
            // Rewind the partial packet. A dropped tlast beat ends the packet
            // by itself, so there is nothing left to discard.
            wr_ptr_nxt = commit_ptr_q;
            drop_evt   = 1'b1;
            if (!s_axis.tlast) begin
              state_nxt = DISCARD;
            end
          end
        end
        DISCARD: begin
          if (s_axis.tlast) begin
            state_nxt = PASS;
          end
        end
        default: state_nxt = PASS;
      endcase
    end
  end

  // ---------------------------------------------------------------- read side
  // Two stages: registered RAM read (ram_*) feeding the output register (out_*).
  // Each stage refills in the same cycle it empties, sustaining 1 beat/cycle.
  logic avail;
  logic out_xfer;
  logic out_load;
  logic rd_en;

  always_comb begin
    avail      = fetch_ptr_q != commit_ptr_q;
    out_xfer   = out_vld && m_axis.tready;
    out_load   = ram_vld && (!out_vld || m_axis.tready);
    rd_en      = avail && (!ram_vld || out_load);
    rd_ptr_nxt = rd_ptr_q + PW'(out_xfer);
  end

  assign m_axis.tvalid = out_vld;
  assign m_axis.tdata  = out_dat.tdata;
  assign m_axis.tkeep  = out_dat.tkeep;
  assign m_axis.tlast  = out_dat.tlast;

  // ---------------------------------------------------------------- registers
  always_ff @(posedge rx_clk) begin
    if (rx_reset) begin
      state_q      <= PASS;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      fetch_ptr_q  <= '0;
      ram_vld      <= 1'b0;
      out_vld      <= 1'b0;
      stretch_q    <= '0;
      fill_q       <= '0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_nxt;
      wr_ptr_q     <= wr_ptr_nxt;
      commit_ptr_q <= commit_ptr_nxt;
      rd_ptr_q     <= rd_ptr_nxt;
      fill_q       <= wr_ptr_nxt - rd_ptr_nxt;

      if (rd_en) begin
        fetch_ptr_q <= fetch_ptr_q + PW'(1);
      end

      if (rd_en) begin
        ram_vld <= 1'b1;
      end else if (out_load) begin
        ram_vld <= 1'b0;
      end

      if (out_load) begin
        out_vld <= 1'b1;
      end else if (out_xfer) begin
        out_vld <= 1'b0;
      end

      // A new drop always restarts the full stretch window.
      if (drop_evt) begin
        stretch_q <= STRETCH_P;
      end else if (stretch_q != '0) begin
        stretch_q <= stretch_q - SW'(1);
      end

      if (drop_evt && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

  // Payload path carries no reset; validity is tracked by ram_vld/out_vld.
  always_ff @(posedge rx_clk) begin
    if (wr_en) begin
      mem[wr_ptr_q[AW-1:0]] <= wr_beat;
    end
    if (rd_en) begin
      ram_dat <= mem[fetch_ptr_q[AW-1:0]];
    end
    if (out_load) begin
      out_dat <= ram_dat;
    end
  end

  assign overrun    = stretch_q != '0;
  assign fill_level = fill_q;
  assign drop_count = drop_q;

endmodule
